test_div_3: RTL and testbench

// - Divisibility-by-3 detector for an unsigned WIDTH-bit word.
// - Zero-latency combinational flag plus a registered copy with residue and valid, for pipelined users.
// - Leaf arithmetic block.
// - Registered outputs are the path used by datapaths.
// - The combinational flag serves checkers and testbenches.

---
 rtl/test_div_3_pkg.sv | 13 +
 rtl/mod3_add.sv | 17 +
 rtl/test_div_3.sv | 82 ++++++++
 tb/tb_test_div_3.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/test_div_3_pkg.sv
// rtl/test_div_3_pkg.sv - shared mod-3 residue type and digit reduction helper
package test_div_3_pkg;

  typedef logic [1:0] mod3_t;

  localparam mod3_t RES_ZERO = 2'd0;

  // A base-4 digit is congruent to itself mod 3, except 3 which folds to 0.
  function automatic mod3_t digit_to_mod3(logic [1:0] d);
    return (d == 2'd3) ? RES_ZERO : mod3_t'(d);
  endfunction

endpackage

// File: rtl/mod3_add.sv
// rtl/mod3_add.sv - combinational adder of two mod-3 residues
import test_div_3_pkg::*;

module mod3_add (
  input  mod3_t a_i,
  input  mod3_t b_i,
  output mod3_t y_o
);

  logic [2:0] sum;

  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i};
    y_o = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
  end

endmodule

// File: rtl/test_div_3.sv
// rtl/test_div_3.sv - divisibility-by-3 detector with combinational and registered results
import test_div_3_pkg::*;

module test_div_3 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             out,
  output logic [1:0]       rem,
  output logic             out_q,
  output logic [1:0]       rem_q,
  output logic             out_valid
);

  localparam int NDIG   = (WIDTH + 1) / 2;
  localparam int LEVELS = $clog2(NDIG);

  logic [2*NDIG-1:0] in_pad;
  assign in_pad = (2*NDIG)'(in);

  // Each level halves the residue count; an unpaired tail residue passes straight through.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int CNT = (NDIG + (1 << l) - 1) >> l;
    mod3_t v [CNT];

    if (l == 0) begin : g_leaf
      for (genvar j = 0; j < CNT; j++) begin : g_dig
        assign v[j] = digit_to_mod3(in_pad[2*j +: 2]);
      end
    end else begin : g_node
      localparam int PCNT = (NDIG + (1 << (l - 1)) - 1) >> (l - 1);
      for (genvar j = 0; j < CNT; j++) begin : g_pair
        if (2*j + 1 < PCNT) begin : g_add
          mod3_add u_add (
            .a_i (g_lvl[l-1].v[2*j]),
            .b_i (g_lvl[l-1].v[2*j+1]),
            .y_o (v[j])
          );
        end else begin : g_pass
          assign v[j] = g_lvl[l-1].v[2*j];
        end
      end
    end
  end

  assign rem = g_lvl[LEVELS].v[0];
  assign out = (rem == RES_ZERO);

  logic  flag_q, flag_d;
  mod3_t res_q, res_d;
  logic  valid_q, valid_d;

  always_comb begin
    flag_d  = flag_q;
    res_d   = res_q;
    valid_d = in_valid;
    if (in_valid) begin
      flag_d = out;
      res_d  = rem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q  <= 1'b0;
      res_q   <= RES_ZERO;
      valid_q <= 1'b0;
    end else begin
      flag_q  <= flag_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign out_q     = flag_q;
  assign rem_q     = res_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_test_div_3.sv
// tb/tb_test_div_3.sv - directed self-checking bench for test_div_3
module tb_test_div_3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in = 32'd0;
  logic        in_valid = 1'b0;
  logic        out;
  logic [1:0]  rem;
  logic        out_q;
  logic [1:0]  rem_q;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  test_div_3 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .in_valid  (in_valid),
    .out       (out),
    .rem       (rem),
    .out_q     (out_q),
    .rem_q     (rem_q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    in = 32'd7;
    #2;
    checks++;
    if (out_q !== 1'b0 || rem_q !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: out_q=%b rem_q=%0d out_valid=%b expected 0 0 0", out_q, rem_q, out_valid);
    end
    checks++;
    if (out !== 1'b0 || rem !== 2'd1) begin
      errors++;
      $display("FAIL reset_comb: out=%b rem=%0d expected 0 1", out, rem);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_small();
    logic [31:0] vals [6] = '{32'd0, 32'd3, 32'd6, 32'd9, 32'd1, 32'd2};
    logic        exp_o [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0]  exp_r [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
    for (int i = 0; i < 6; i++) begin
      in = vals[i];
      #1;
      checks++;
      if (out !== exp_o[i] || rem !== exp_r[i]) begin
        errors++;
        $display("FAIL small in=%0d: out=%b rem=%0d expected %b %0d", vals[i], out, rem, exp_o[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_all_ones();
    logic [31:0] vals [3] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFD};
    logic        exp_o [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  exp_r [3] = '{2'd0, 2'd2, 2'd1};
    for (int i = 0; i < 3; i++) begin
      in = vals[i];
      #1;
      checks++;
      if (out !== exp_o[i] || rem !== exp_r[i]) begin
        errors++;
        $display("FAIL all_ones in=%h: out=%b rem=%0d expected %b %0d", vals[i], out, rem, exp_o[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [31:0] v;
    logic [1:0]  er;
    v = 32'hFFFFFFFF - 32'd100000;
    for (int i = 0; i < 100040; i++) begin
      in = v;
      #1;
      er = 2'(v % 32'd3);
      checks++;
      if (out !== (er == 2'd0) || rem !== er) begin
        errors++;
        $display("FAIL sweep in=%h: out=%b rem=%0d expected %b %0d", v, out, rem, (er == 2'd0), er);
      end
      v = v + 32'd1;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3] = '{32'd9, 32'd10, 32'd11};
    logic        exp_o [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  exp_r [3] = '{2'd0, 2'd1, 2'd2};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in = vals[i];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_q !== exp_o[i] || rem_q !== exp_r[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back in=%0d: out_q=%b rem_q=%0d out_valid=%b expected %b %0d 1",
                 vals[i], out_q, rem_q, out_valid, exp_o[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] vals [3] = '{32'd4, 32'd6, 32'd8};
    logic        vin  [3] = '{1'b1, 1'b0, 1'b1};
    logic        exp_o [3] = '{1'b0, 1'b0, 1'b0};
    logic [1:0]  exp_r [3] = '{2'd1, 2'd1, 2'd2};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in = vals[i];
      in_valid = vin[i];
      @(posedge clk);
      #1;
      checks++;
      if (out_q !== exp_o[i] || rem_q !== exp_r[i] || out_valid !== vin[i]) begin
        errors++;
        $display("FAIL hold step%0d: out_q=%b rem_q=%0d out_valid=%b expected %b %0d %b",
                 i, out_q, rem_q, out_valid, exp_o[i], exp_r[i], vin[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in = 32'd12;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    checks++;
    if (out_q !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: out_q=%b out_valid=%b expected 1 1", out_q, out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_q !== 1'b0 || rem_q !== 2'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: out_q=%b rem_q=%0d out_valid=%b expected 0 0 0", out_q, rem_q, out_valid);
    end
    in = 32'd5;
    #1;
    checks++;
    if (out !== 1'b0 || rem !== 2'd2) begin
      errors++;
      $display("FAIL comb_in_reset: out=%b rem=%0d expected 0 2", out, rem);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: out_q=%b out_valid=%b expected 0 0", out_q, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in = 32'd15;
    in_valid = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release_early: out_valid=%b expected 0", out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_q !== 1'b1 || rem_q !== 2'd0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_release: out_q=%b rem_q=%0d out_valid=%b expected 1 0 1", out_q, rem_q, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_small();
    test_all_ones();
    test_sweep();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
